// File: rtl/writeback_stage_pkg.sv
// Shared definitions for the writeback stage: field widths, regsel encodings
// and the EX/WB pipeline register payload.
package writeback_stage_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_AW = 5;
    localparam int unsigned SEL_W  = 2;

    localparam logic [SEL_W-1:0] REGSEL_ALU = 2'd0;
    localparam logic [SEL_W-1:0] REGSEL_HI  = 2'd1;
    localparam logic [SEL_W-1:0] REGSEL_LO  = 2'd2;
    localparam logic [SEL_W-1:0] REGSEL_RSV = 2'd3;

    // EX/WB register contents; an all-zero value is a bubble
    typedef struct packed {
        logic              regwrite;
        logic [SEL_W-1:0]  regsel;
        logic              gpio_in;
        logic [REG_AW-1:0] dest;
        logic [XLEN-1:0]   alu_result;
        logic [XLEN-1:0]   gpio_data;
    } ex_wb_t;

endpackage

// File: rtl/hilo_reg.sv
// Architectural HI/LO register pair.
// Ports: clk, rst (sync, active-high), en (load both), hi_d/lo_d (next values),
//        hi_q/lo_q (current values).
module hilo_reg
    import writeback_stage_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [XLEN-1:0] hi_d,
    input  logic [XLEN-1:0] lo_d,
    output logic [XLEN-1:0] hi_q,
    output logic [XLEN-1:0] lo_q
);

    logic [XLEN-1:0] r_hi;
    logic [XLEN-1:0] r_lo;

    // Both halves always load together (mult/multu result)
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (en) begin
            r_hi <= hi_d;
            r_lo <= lo_d;
        end
    end

    assign hi_q = r_hi;
    assign lo_q = r_lo;

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: EX/WB pipeline register, writeback data select, HI/LO and
// GPIO output registers.
// Ports: clk, rst (sync, active-high), stall, flush, EX-stage controls and data
//        (*_EX), gpio_in_data pins; outputs regwrite_WB/writeaddr_WB/
//        writedata_WB to the register file, hi_q/lo_q, gpio_out.
// Optional build macro: GPIO_SYNC_EN adds a two-flop synchronizer on
// gpio_in_data.
module writeback_stage
    import writeback_stage_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              regwrite_EX,
    input  logic [SEL_W-1:0]  regsel_EX,
    input  logic              enhilo_EX,
    input  logic              rdrt_EX,
    input  logic              gpio_out_EX,
    input  logic              gpio_in_EX,
    input  logic [REG_AW-1:0] rd_EX,
    input  logic [REG_AW-1:0] rt_EX,
    input  logic [XLEN-1:0]   alu_result_EX,
    input  logic [XLEN-1:0]   alu_hi_EX,
    input  logic [XLEN-1:0]   gpio_in_data,
    output logic              regwrite_WB,
    output logic [REG_AW-1:0] writeaddr_WB,
    output logic [XLEN-1:0]   writedata_WB,
    output logic [XLEN-1:0]   hi_q,
    output logic [XLEN-1:0]   lo_q,
    output logic [XLEN-1:0]   gpio_out
);

    logic [XLEN-1:0] w_gpio_sample;
    logic            w_commit;
    ex_wb_t          w_ex_next;
    ex_wb_t          r_exwb;
    logic [XLEN-1:0] r_gpio_out;
    logic            w_regwrite;
    logic [XLEN-1:0] w_wdata;

`ifdef GPIO_SYNC_EN
    logic [XLEN-1:0] r_sync1;
    logic [XLEN-1:0] r_sync2;

    // Metastability guard; runs every cycle independent of stall
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= gpio_in_data;
            r_sync2 <= r_sync1;
        end
    end

    assign w_gpio_sample = r_sync2;
`else
    assign w_gpio_sample = gpio_in_data;
`endif

    // Side effects of the EX instruction happen only if it actually advances
    assign w_commit = ~stall & ~flush;

    // Next EX/WB payload, destination resolved before capture
    always_comb begin
        w_ex_next            = '0;
        w_ex_next.regwrite   = regwrite_EX;
        w_ex_next.regsel     = regsel_EX;
        w_ex_next.gpio_in    = gpio_in_EX;
        w_ex_next.dest       = rdrt_EX ? rt_EX : rd_EX;
        w_ex_next.alu_result = alu_result_EX;
        w_ex_next.gpio_data  = gpio_in_EX ? w_gpio_sample : '0;
    end

    // EX/WB register: stall holds, flush inserts a bubble
    always_ff @(posedge clk) begin
        if (rst) begin
            r_exwb <= '0;
        end else if (!stall) begin
            r_exwb <= flush ? '0 : w_ex_next;
        end
    end

    hilo_reg u_hilo (
        .clk  (clk),
        .rst  (rst),
        .en   (w_commit & enhilo_EX),
        .hi_d (alu_hi_EX),
        .lo_d (alu_result_EX),
        .hi_q (hi_q),
        .lo_q (lo_q)
    );

    // GPIO output register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_gpio_out <= '0;
        end else if (w_commit && gpio_out_EX) begin
            r_gpio_out <= alu_result_EX;
        end
    end

    assign gpio_out = r_gpio_out;

    // Writeback select; $zero is never written, reserved regsel suppresses write
    always_comb begin
        w_regwrite = r_exwb.regwrite && (r_exwb.dest != '0);
        w_wdata    = '0;
        case (r_exwb.regsel)
            REGSEL_ALU: w_wdata = r_exwb.alu_result;
            REGSEL_HI:  w_wdata = r_exwb.gpio_in ? r_exwb.gpio_data : hi_q;
            REGSEL_LO:  w_wdata = lo_q;
            default: begin
                w_wdata    = '0;
                w_regwrite = 1'b0;
            end
        endcase
    end

    assign regwrite_WB  = w_regwrite;
    assign writeaddr_WB = r_exwb.dest;
    assign writedata_WB = w_wdata;

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: directed scenarios followed by
// randomized traffic compared against a cycle-level behavioural model.
module tb_writeback_stage;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        regwrite_EX;
    logic [1:0]  regsel_EX;
    logic        enhilo_EX;
    logic        rdrt_EX;
    logic        gpio_out_EX;
    logic        gpio_in_EX;
    logic [4:0]  rd_EX;
    logic [4:0]  rt_EX;
    logic [31:0] alu_result_EX;
    logic [31:0] alu_hi_EX;
    logic [31:0] gpio_in_data;
    logic        regwrite_WB;
    logic [4:0]  writeaddr_WB;
    logic [31:0] writedata_WB;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic [31:0] gpio_out;

    int n_vec;
    int n_err;

    // Model state: what the WB stage architecturally holds
    logic        m_rw;
    logic [1:0]  m_sel;
    logic        m_gin;
    logic [4:0]  m_dest;
    logic [31:0] m_alu;
    logic [31:0] m_gdata;
    logic [31:0] m_hi;
    logic [31:0] m_lo;
    logic [31:0] m_gout;
    logic [31:0] m_pin1;   // pins seen at previous edge
    logic [31:0] m_pin2;   // pins seen two edges ago

    writeback_stage dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .flush        (flush),
        .regwrite_EX  (regwrite_EX),
        .regsel_EX    (regsel_EX),
        .enhilo_EX    (enhilo_EX),
        .rdrt_EX      (rdrt_EX),
        .gpio_out_EX  (gpio_out_EX),
        .gpio_in_EX   (gpio_in_EX),
        .rd_EX        (rd_EX),
        .rt_EX        (rt_EX),
        .alu_result_EX(alu_result_EX),
        .alu_hi_EX    (alu_hi_EX),
        .gpio_in_data (gpio_in_data),
        .regwrite_WB  (regwrite_WB),
        .writeaddr_WB (writeaddr_WB),
        .writedata_WB (writedata_WB),
        .hi_q         (hi_q),
        .lo_q         (lo_q),
        .gpio_out     (gpio_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_idle();
        stall         = 1'b0;
        flush         = 1'b0;
        regwrite_EX   = 1'b0;
        regsel_EX     = 2'd0;
        enhilo_EX     = 1'b0;
        rdrt_EX       = 1'b0;
        gpio_out_EX   = 1'b0;
        gpio_in_EX    = 1'b0;
        rd_EX         = 5'd0;
        rt_EX         = 5'd0;
        alu_result_EX = 32'h0;
        alu_hi_EX     = 32'h0;
    endtask

    // Apply the architectural effect of one clock edge with the current inputs
    task automatic model_edge();
        logic [31:0] sample;
`ifdef GPIO_SYNC_EN
        sample = m_pin2;
`else
        sample = gpio_in_data;
`endif
        if (rst) begin
            m_rw = 0; m_sel = 0; m_gin = 0; m_dest = 0; m_alu = 0; m_gdata = 0;
            m_hi = 0; m_lo = 0; m_gout = 0; m_pin1 = 0; m_pin2 = 0;
        end else begin
            m_pin2 = m_pin1;
            m_pin1 = gpio_in_data;
            if (!stall) begin
                if (flush) begin
                    m_rw = 0; m_sel = 0; m_gin = 0; m_dest = 0; m_alu = 0; m_gdata = 0;
                end else begin
                    m_rw    = regwrite_EX;
                    m_sel   = regsel_EX;
                    m_gin   = gpio_in_EX;
                    m_dest  = rdrt_EX ? rt_EX : rd_EX;
                    m_alu   = alu_result_EX;
                    m_gdata = sample;
                    if (enhilo_EX) begin
                        m_hi = alu_hi_EX;
                        m_lo = alu_result_EX;
                    end
                    if (gpio_out_EX) m_gout = alu_result_EX;
                end
            end
        end
    endtask

    task automatic compare_model();
        logic        exp_we;
        logic [31:0] exp_wd;
        exp_we = m_rw && (m_dest != 5'd0) && (m_sel != 2'd3);
        case (m_sel)
            2'd0:    exp_wd = m_alu;
            2'd1:    exp_wd = m_gin ? m_gdata : m_hi;
            2'd2:    exp_wd = m_lo;
            default: exp_wd = 32'h0;
        endcase
        check("we", 32'(regwrite_WB), 32'(exp_we));
        if (exp_we || m_sel == 2'd3) check("wdata", writedata_WB, exp_wd);
        if (exp_we) check("waddr", 32'(writeaddr_WB), 32'(m_dest));
        check("hi", hi_q, m_hi);
        check("lo", lo_q, m_lo);
        check("gpio_out", gpio_out, m_gout);
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        compare_model();
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        m_pin1 = 0;
        m_pin2 = 0;
        set_idle();
        gpio_in_data = 32'h0;
        rst = 1'b1;
        // Instruction in EX during reset must be discarded
        regwrite_EX = 1'b1; enhilo_EX = 1'b1; gpio_out_EX = 1'b1;
        rd_EX = 5'd9; alu_result_EX = 32'hDEAD_BEEF; alu_hi_EX = 32'h1234_5678;
        step();
        stall = 1'b1;
        step();
        check("rst_we", 32'(regwrite_WB), 32'h0);
        check("rst_hi", hi_q, 32'h0);
        check("rst_gpio", gpio_out, 32'h0);
        rst = 1'b0;
        set_idle();
        step();

        // add rd=5
        regwrite_EX = 1'b1; rd_EX = 5'd5; alu_result_EX = 32'h7;
        step();
        check("add_we", 32'(regwrite_WB), 32'h1);
        check("add_addr", 32'(writeaddr_WB), 32'd5);
        check("add_data", writedata_WB, 32'h7);

        // stall+flush over addi rt=0: everything holds
        regwrite_EX = 1'b1; rdrt_EX = 1'b1; rt_EX = 5'd0; rd_EX = 5'd12;
        alu_result_EX = 32'h9; stall = 1'b1; flush = 1'b1;
        step();
        check("hold_we", 32'(regwrite_WB), 32'h1);
        check("hold_addr", 32'(writeaddr_WB), 32'd5);
        check("hold_data", writedata_WB, 32'h7);
        stall = 1'b0; flush = 1'b0;
        step();
        check("r0_we", 32'(regwrite_WB), 32'h0);
        check("r0_addr", 32'(writeaddr_WB), 32'd0);
        set_idle();

        // mult then mfhi rd=3
        enhilo_EX = 1'b1; alu_hi_EX = 32'h1; alu_result_EX = 32'h2;
        step();
        set_idle();
        regwrite_EX = 1'b1; regsel_EX = 2'd1; rd_EX = 5'd3;
        step();
        check("mult_hi", hi_q, 32'h1);
        check("mult_lo", lo_q, 32'h2);
        check("mfhi_we", 32'(regwrite_WB), 32'h1);
        check("mfhi_addr", 32'(writeaddr_WB), 32'd3);
        check("mfhi_data", writedata_WB, 32'h1);
        set_idle();

        // mflo and reserved regsel
        regwrite_EX = 1'b1; regsel_EX = 2'd2; rd_EX = 5'd4;
        step();
        check("mflo_data", writedata_WB, 32'h2);
        regsel_EX = 2'd3; alu_result_EX = 32'h55;
        step();
        check("rsv_we", 32'(regwrite_WB), 32'h0);
        check("rsv_data", writedata_WB, 32'h0);
        set_idle();

        // srl-gpio: output register plus GPR write
        regwrite_EX = 1'b1; gpio_out_EX = 1'b1; rd_EX = 5'd6; alu_result_EX = 32'hA5A5_0000;
        step();
        check("gout", gpio_out, 32'hA5A5_0000);
        check("gout_we", 32'(regwrite_WB), 32'h1);
        check("gout_data", writedata_WB, 32'hA5A5_0000);
        set_idle();

        // sra-gpio: read pins
`ifdef GPIO_SYNC_EN
        gpio_in_data = 32'h11;
        step();
        step();
        gpio_in_data = 32'hFF;
        step();
        regwrite_EX = 1'b1; regsel_EX = 2'd1; gpio_in_EX = 1'b1; rd_EX = 5'd8;
        step();
        check("gin_sync_old", writedata_WB, 32'h11);
        step();
        check("gin_sync_new", writedata_WB, 32'hFF);
`else
        gpio_in_data = 32'hFF;
        regwrite_EX = 1'b1; regsel_EX = 2'd1; gpio_in_EX = 1'b1; rd_EX = 5'd8;
        step();
        check("gin_data", writedata_WB, 32'hFF);
`endif
        set_idle();

        // reset in the middle of a mult
        enhilo_EX = 1'b1; alu_hi_EX = 32'hCAFE_0001; alu_result_EX = 32'hBEEF_0002;
        gpio_out_EX = 1'b1; rst = 1'b1;
        step();
        check("rmult_hi", hi_q, 32'h0);
        check("rmult_lo", lo_q, 32'h0);
        check("rmult_gout", gpio_out, 32'h0);
        rst = 1'b0;
        set_idle();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst           = ($urandom_range(0, 63) == 0);
            stall         = ($urandom_range(0, 7) == 0);
            flush         = ($urandom_range(0, 7) == 0);
            regwrite_EX   = 1'($urandom_range(0, 1));
            regsel_EX     = 2'($urandom_range(0, 3));
            enhilo_EX     = ($urandom_range(0, 3) == 0);
            rdrt_EX       = 1'($urandom_range(0, 1));
            gpio_out_EX   = ($urandom_range(0, 3) == 0);
            gpio_in_EX    = 1'($urandom_range(0, 1));
            rd_EX         = 5'($urandom_range(0, 31));
            rt_EX         = 5'($urandom_range(0, 31));
            alu_result_EX = $urandom;
            alu_hi_EX     = $urandom;
            if ($urandom_range(0, 2) == 0) gpio_in_data = $urandom;
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
